rot_shift_pipe: RTL and testbench
=================================

ROT_SHIFT_PIPE -- requirements
Module: rot_shift_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand and result width; legal values are powers of two, 8 to 64.
REQ-002 SHALL derive localparam SH_W = log2(DATA_WIDTH), which is both the shift-amount width and the number of pipeline stages.
REQ-003 SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port clear, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit, meaning A/B/op present a request this cycle.
REQ-006 SHALL have port in_ready, output, 1 bit, meaning a request is accepted this cycle when in_valid is also 1.
REQ-007 SHALL have port A, input, DATA_WIDTH bits, the operand.
REQ-008 SHALL have port B, input, DATA_WIDTH bits, the shift amount; only B[SH_W-1:0] is used and upper bits are ignored.
REQ-009 SHALL have port op, input, 3 bits, the operation: 000 ROR, 001 ROL, 010 SHR (logical), 011 SHL, 100 SHRA (arithmetic), 101-111 pass-through.
REQ-010 SHALL have port out_valid, output, 1 bit, meaning Z holds a completed result.
REQ-011 SHALL have port out_ready, input, 1 bit, meaning downstream accepts Z this cycle.
REQ-012 SHALL have port Z, output, DATA_WIDTH bits, the result.
REQ-013 SHALL have port busy, output, 1 bit, equal to 1 while any pipeline stage holds a valid entry.

Function
REQ-014 SHALL implement SH_W registered stages; stage k conditionally shifts/rotates by 2^k, controlled by amount bit k.
REQ-015 Each stage SHALL carry data, remaining amount bits, op and a valid bit.
REQ-016 Latency SHALL be exactly SH_W cycles from an accepted request to out_valid, with no stall in between (5 cycles at DATA_WIDTH=32).
REQ-017 Throughput SHALL be one request per cycle when out_ready is held at 1.
REQ-018 Pipeline stall SHALL occur iff out_valid=1 and out_ready=0; a stall freezes every stage register.
REQ-019 in_ready SHALL be the inverse of the stall condition (combinational); it SHALL NOT depend on in_valid.
REQ-020 A request with in_valid=1 and in_ready=0 SHALL NOT be captured; the upstream holds it.
REQ-021 Bubbles (valid=0) SHALL advance through the pipeline whenever there is no stall; collapsing bubbles is not required.
REQ-022 Z and out_valid SHALL be driven directly from the last stage registers.
REQ-023 ROR and ROL by amount n SHALL equal rotation modulo DATA_WIDTH; n=0 SHALL return A unchanged.
REQ-024 SHR and SHL SHALL fill vacated bits with 0.
REQ-025 SHRA SHALL fill vacated bits with the operand's bit DATA_WIDTH-1.
REQ-026 Pass-through ops SHALL return A unchanged after the same latency.
REQ-027 Shift amounts of DATA_WIDTH or more SHALL use the low SH_W bits only (amount 35 at width 32 acts as 3).
REQ-028 Simultaneous accept and output (in_valid, in_ready, out_valid, out_ready all 1) SHALL capture the new request and retire the old result in the same edge.
REQ-029 Z SHALL be held stable while out_valid=1 and out_ready=0.

Reset
REQ-030 Asserting clear SHALL immediately, without waiting for a clock edge, force all stage valid bits, out_valid and busy to 0.
REQ-031 Asserting clear SHALL force Z and all stage data registers to 0.
REQ-032 in_ready SHALL be 1 while clear is asserted and after it is released.
REQ-033 Reset during operation SHALL discard all in-flight requests; no result for those requests SHALL appear after release.
REQ-034 The first request SHALL be acceptable on the first rising edge after clear deasserts.

Verification
REQ-035 Basic ROR latency: W=32, ROR, A=0x80000001, B=1, out_ready=1 -> Z=0xC0000000 with out_valid high exactly 5 cycles after acceptance.
REQ-036 Per-mode results: A=0x80000000, B=31 -> SHRA gives 0xFFFFFFFF, SHR gives 0x00000001, ROL gives 0x40000000, SHL gives 0x00000000; ROL with A=0x80000001, B=4 gives 0x00000018.
REQ-037 Amount masking and pass-through: ROR with B=0x00000023 gives the same result as B=3; op=111 returns A unchanged.
REQ-038 Back-to-back streaming: 10 consecutive requests with out_ready=1 -> 10 results in order on consecutive cycles, starting at cycle 5.
REQ-039 Backpressure: out_ready held at 0 for 4 cycles with the pipeline full -> in_ready=0, Z stable, no request lost or duplicated after release.
REQ-040 Reset mid-flight: clear asserted with 3 requests in flight -> out_valid=0 and busy=0 immediately, no stale result after release, and a new request returns its correct result in 5 cycles.

Source files
------------

// File: rtl/rot_shift_pipe.sv
// rot_shift_pipe: barrel rotate/shift unit split into log2(DATA_WIDTH)
// registered stages. Stage k applies the 2^k step when amount bit k is set.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is purely the inverse of the output stall (out_valid=1,
// out_ready=0) and never looks at in_valid; a stall freezes every stage.
// out_valid/Z come straight from the last stage registers and hold steady
// while stalled.
module rot_shift_pipe #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [2:0]            op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Z,
  output logic                  busy
);

  localparam int SH_W = $clog2(DATA_WIDTH);

  localparam logic [2:0] OP_ROR  = 3'b000;
  localparam logic [2:0] OP_ROL  = 3'b001;
  localparam logic [2:0] OP_SHR  = 3'b010;
  localparam logic [2:0] OP_SHL  = 3'b011;
  localparam logic [2:0] OP_SHRA = 3'b100;

  // Stage registers: data, amount bits still to apply, op, valid.
  logic [DATA_WIDTH-1:0] s_data [SH_W];
  logic [SH_W-1:0]       s_amt  [SH_W];
  logic [2:0]            s_op   [SH_W];
  logic [SH_W-1:0]       s_vld;

  // What each stage sees on its input side.
  logic [DATA_WIDTH-1:0] src_data [SH_W];
  logic [SH_W-1:0]       src_amt  [SH_W];
  logic [2:0]            src_op   [SH_W];
  logic [SH_W-1:0]       src_vld;
  logic [DATA_WIDTH-1:0] nxt_data [SH_W];

  logic stall;
  logic unused_sink;

  // One fixed-size step of the selected operation; en=0 passes d through.
  // Because sh < DATA_WIDTH, the rotate's complementary shift is never zero.
  function automatic logic [DATA_WIDTH-1:0] shift_step(
    input logic [DATA_WIDTH-1:0] d,
    input logic [2:0]            o,
    input logic                  en,
    input int                    sh
  );
    logic [DATA_WIDTH-1:0] r;
    r = d;
    if (en) begin
      case (o)
        OP_ROR:  r = (d >> sh) | (d << (DATA_WIDTH - sh));
        OP_ROL:  r = (d << sh) | (d >> (DATA_WIDTH - sh));
        OP_SHR:  r = d >> sh;
        OP_SHL:  r = d << sh;
        // Sign bit is never changed by an arithmetic step, so chaining
        // steps keeps filling with the original operand's MSB.
        OP_SHRA: r = $signed(d) >>> sh;
        default: r = d;
      endcase
    end
    return r;
  endfunction

  assign out_valid = s_vld[SH_W-1];
  assign Z         = s_data[SH_W-1];
  assign busy      = |s_vld;
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;

  // Upper B bits and the last stage's leftover amount/op are never needed.
  assign unused_sink = ^{B[DATA_WIDTH-1:SH_W], s_amt[SH_W-1], s_op[SH_W-1]};

  // Route the request into stage 0 and each stage's output into the next.
  always_comb begin
    src_data[0] = A;
    src_amt[0]  = B[SH_W-1:0];
    src_op[0]   = op;
    src_vld     = '0;
    src_vld[0]  = in_valid;
    for (int k = 1; k < SH_W; k++) begin
      src_data[k] = s_data[k-1];
      src_amt[k]  = s_amt[k-1];
      src_op[k]   = s_op[k-1];
      src_vld[k]  = s_vld[k-1];
    end
  end

  // Per-stage datapath: stage k acts on amount bit k with step 2^k.
  always_comb begin
    for (int k = 0; k < SH_W; k++) begin
      nxt_data[k] = shift_step(src_data[k], src_op[k], src_amt[k][k], 1 << k);
    end
  end

  // Stage registers: cleared asynchronously, frozen as a whole on stall.
  // Bubbles advance like any entry so a held stall is the only hold state.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int k = 0; k < SH_W; k++) begin
        s_data[k] <= '0;
        s_amt[k]  <= '0;
        s_op[k]   <= '0;
      end
      s_vld <= '0;
    end else if (!stall) begin
      for (int k = 0; k < SH_W; k++) begin
        s_data[k] <= nxt_data[k];
        s_amt[k]  <= src_amt[k];
        s_op[k]   <= src_op[k];
      end
      s_vld <= src_vld;
    end
  end

endmodule

// File: tb/tb_rot_shift_pipe.sv
// Testbench for rot_shift_pipe at DATA_WIDTH=32: directed cases, streaming,
// backpressure, mid-flight reset and a randomized phase, all scored against
// a bit-level reference model and an expected-result queue.
module tb_rot_shift_pipe;

  localparam int W    = 32;
  localparam int SH_W = 5;

  logic         clk;
  logic         clear;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [2:0]   op_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] z_out;
  logic         busy;

  rot_shift_pipe #(.DATA_WIDTH(W)) dut (
    .clock(clk), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .A(a_in), .B(b_in), .op(op_in), .out_valid(out_valid),
    .out_ready(out_ready), .Z(z_out), .busy(busy)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  int           acc_cyc_q[$];
  int           acc_stall_q[$];
  logic [W-1:0] pending_exp;
  int           cyc;
  int           stall_cnt;
  int           n_retired;
  int           n_checks;
  int           n_miss;
  bit           head_seen;
  bit           acc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: each result bit named directly from operand bits.
  function automatic logic [W-1:0] ref_model(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic [2:0]   o);
    logic [W-1:0] r;
    int n;
    n = int'(b % W);
    for (int i = 0; i < W; i++) begin
      case (o)
        3'd0:    r[i] = a[(i + n) % W];
        3'd1:    r[i] = a[(i - n + W) % W];
        3'd2:    r[i] = (i + n < W) ? a[i + n] : 1'b0;
        3'd3:    r[i] = (i >= n) ? a[i - n] : 1'b0;
        3'd4:    r[i] = (i + n < W) ? a[i + n] : a[W-1];
        default: r[i] = a[i];
      endcase
    end
    return r;
  endfunction

  // Output-side checks, done 1 time unit after each rising edge.
  task automatic check_outputs();
    int eff;
    chk("busy", {63'd0, busy}, {63'd0, exp_q.size() != 0});
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", {63'd0, out_valid}, 64'd0);
      end else begin
        chk("z", {32'd0, z_out}, {32'd0, exp_q[0]});
        if (!head_seen) begin
          eff = cyc - acc_cyc_q[0] - (stall_cnt - acc_stall_q[0]);
          chk("latency", 64'(eff), 64'(SH_W - 1));
          head_seen = 1'b1;
        end
      end
    end else if (exp_q.size() != 0 && !head_seen) begin
      eff = cyc - acc_cyc_q[0] - (stall_cnt - acc_stall_q[0]);
      if (eff > SH_W - 1) chk("late_result", {63'd0, out_valid}, 64'd1);
    end
  endtask

  // One clock: decide handshakes from settled signals, cross the edge,
  // update the scoreboard, then check outputs.
  task automatic tick();
    bit ret;
    bit stall_now;
    #1;
    acc       = in_valid && in_ready;
    ret       = out_valid && out_ready;
    stall_now = out_valid && !out_ready;
    chk("in_ready", {63'd0, in_ready}, {63'd0, !stall_now});
    @(posedge clk);
    cyc++;
    if (stall_now) stall_cnt++;
    if (ret && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      void'(acc_cyc_q.pop_front());
      void'(acc_stall_q.pop_front());
      head_seen = 1'b0;
      n_retired++;
    end
    if (acc) begin
      exp_q.push_back(pending_exp);
      acc_cyc_q.push_back(cyc);
      acc_stall_q.push_back(stall_cnt);
    end
    #1;
    check_outputs();
  endtask

  // Driver tasks
  task automatic drive_req(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2:0] o, input logic [W-1:0] e);
    in_valid    = 1'b1;
    a_in        = a;
    b_in        = b;
    op_in       = o;
    pending_exp = e;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2:0] o, input logic [W-1:0] e);
    int guard;
    drive_req(a, b, o, e);
    guard = 0;
    do begin
      tick();
      guard++;
    end while (!acc && guard < 50);
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain();
    int guard;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      tick();
      guard++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // Watchdog
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b;
    logic [2:0]   o;
    int base;

    n_checks = 0; n_miss = 0; cyc = 0; stall_cnt = 0; n_retired = 0;
    head_seen = 1'b0; acc = 1'b0;
    clear = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a_in = '0; b_in = '0; op_in = '0; pending_exp = '0;

    // Reset state
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_z", {32'd0, z_out}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    clear = 1'b0;

    // Directed per-mode results
    send(32'h8000_0001, 32'd1, 3'b000, 32'hC000_0000);
    send(32'h8000_0000, 32'd31, 3'b100, 32'hFFFF_FFFF);
    send(32'h8000_0000, 32'd31, 3'b010, 32'h0000_0001);
    send(32'h8000_0000, 32'd31, 3'b001, 32'h4000_0000);
    send(32'h8000_0000, 32'd31, 3'b011, 32'h0000_0000);
    send(32'h8000_0001, 32'd4, 3'b001, 32'h0000_0018);
    send(32'h1234_5678, 32'd3, 3'b000, 32'h0246_8ACF);
    send(32'h1234_5678, 32'h23, 3'b000, 32'h0246_8ACF);
    send(32'hDEAD_BEEF, 32'd7, 3'b111, 32'hDEAD_BEEF);
    send(32'h8765_4321, 32'd0, 3'b001, 32'h8765_4321);
    drain();

    // Back-to-back streaming of 10 requests
    base = n_retired;
    for (int i = 0; i < 10; i++) begin
      a = $urandom; b = $urandom; o = 3'($urandom_range(0, 7));
      send(a, b, o, ref_model(a, b, o));
    end
    drain();
    chk("stream_count", 64'(n_retired - base), 64'd10);

    // Backpressure with a full pipeline
    base = n_retired;
    for (int i = 0; i < 5; i++) begin
      a = $urandom; b = $urandom; o = 3'($urandom_range(0, 4));
      send(a, b, o, ref_model(a, b, o));
    end
    a = $urandom; b = $urandom; o = 3'($urandom_range(0, 4));
    drive_req(a, b, o, ref_model(a, b, o));
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    while (!acc && in_valid) begin
      tick();
      if (acc) in_valid = 1'b0;
    end
    drain();
    chk("bp_count", 64'(n_retired - base), 64'd6);

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        a = $urandom; b = $urandom; o = 3'($urandom_range(0, 7));
        drive_req(a, b, o, ref_model(a, b, o));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (acc) in_valid = 1'b0;
    end
    drain();

    // Reset with 3 requests in flight
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom; o = 3'($urandom_range(0, 4));
      send(a, b, o, ref_model(a, b, o));
    end
    in_valid = 1'b0;
    #2;
    clear = 1'b1;
    #1;
    chk("clr_out_valid", {63'd0, out_valid}, 64'd0);
    chk("clr_busy", {63'd0, busy}, 64'd0);
    chk("clr_z", {32'd0, z_out}, 64'd0);
    chk("clr_in_ready", {63'd0, in_ready}, 64'd1);
    exp_q.delete();
    acc_cyc_q.delete();
    acc_stall_q.delete();
    head_seen = 1'b0;
    @(posedge clk);
    #1;
    clear = 1'b0;
    send(32'h0000_00F0, 32'd4, 3'b010, 32'h0000_000F);
    chk("first_accept", {63'd0, acc}, 64'd1);
    idle(8);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
    $finish;
  end

endmodule
